// File: rtl/riscv_pkg.sv
// Shared RISC-V decode definitions: opcodes, the NOP encoding, the ID/EX
// register layout and the decode sequencer state.
package riscv_pkg;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] JAL    = 7'b1101111;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // PC width carried by id_ex_t; users must instantiate with XLEN equal to this.
  localparam int PKG_XLEN = 32;

  typedef struct packed {
    logic                valid;
    logic [PKG_XLEN-1:0] pc;
    logic [31:0]         imm;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [4:0]          rd;
    logic [6:0]          opcode;
    logic [2:0]          funct3;
  } id_ex_t;

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} ctrl_state_t;

endpackage

// File: rtl/decode_issue_ctrl_hazard_detect.sv
// Load-use hazard check between the instruction in IF/ID and a load in ID/EX.
module hazard_detect
  import riscv_pkg::*;
(
  input  logic       ifid_vld,
  input  logic [6:0] ifid_opcode,
  input  logic [4:0] ifid_rs1,
  input  logic [4:0] ifid_rs2,
  input  logic       idex_vld,
  input  logic [6:0] idex_opcode,
  input  logic [4:0] idex_rd,
  output logic       stall
);

  logic rs1_used;
  logic rs2_used;

  always_comb begin
    rs1_used = (ifid_opcode == OP_IMM) || (ifid_opcode == LOAD) ||
               (ifid_opcode == STORE)  || (ifid_opcode == BRANCH) ||
               (ifid_opcode == OP)     || (ifid_opcode == JALR);
    rs2_used = (ifid_opcode == STORE) || (ifid_opcode == BRANCH) ||
               (ifid_opcode == OP);
    stall = idex_vld && (idex_opcode == LOAD) && (idex_rd != 5'd0) && ifid_vld &&
            ((rs1_used && (ifid_rs1 == idex_rd)) || (rs2_used && (ifid_rs2 == idex_rd)));
  end

endmodule

// File: rtl/decode_issue_ctrl.sv
// Decode-stage sequencer: owns IF/ID and ID/EX, inserts load-use bubbles,
// honours EX backpressure and drops wrong-path fetches after a redirect.
module decode_issue_ctrl
  import riscv_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid,
  input  logic [31:0]      if_instr,
  input  logic [XLEN-1:0]  if_pc,
  output logic             if_ready,
  output logic [31:0]      id_instr,
  input  logic [31:0]      imm_in,
  input  logic             ex_ready,
  input  logic             redirect,
  output logic             id_ex_valid,
  output logic [XLEN-1:0]  id_ex_pc,
  output logic [31:0]      id_ex_imm,
  output logic [4:0]       id_ex_rs1,
  output logic [4:0]       id_ex_rs2,
  output logic [4:0]       id_ex_rd,
  output logic [6:0]       id_ex_opcode,
  output logic [2:0]       id_ex_funct3,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  ctrl_state_t       state;
  logic [2:0]        flush_cnt;
  logic              ifid_vld_p0;
  logic [31:0]       ifid_instr_p0;
  logic [XLEN-1:0]   ifid_pc_p0;
  id_ex_t            id_ex_p1;
  id_ex_t            id_ex_nxt;
  logic [CNT_W-1:0]  bubble_q;
  logic              stall_ld;
  logic              advance;
  logic              accept;

  hazard_detect u_hazard (
    .ifid_vld    (ifid_vld_p0),
    .ifid_opcode (ifid_instr_p0[6:0]),
    .ifid_rs1    (ifid_instr_p0[19:15]),
    .ifid_rs2    (ifid_instr_p0[24:20]),
    .idex_vld    (id_ex_p1.valid),
    .idex_opcode (id_ex_p1.opcode),
    .idex_rd     (id_ex_p1.rd),
    .stall       (stall_ld)
  );

  always_comb begin
    advance  = !redirect && ex_ready && !stall_ld;
    // FLUSH keeps fetch flowing so the wrong-path instructions drain and are dropped.
    if_ready = redirect ? 1'b0 : ((state == FLUSH) ? 1'b1 : advance);
    accept   = advance && (state == RUN) && if_valid;

    id_ex_nxt        = '0;
    id_ex_nxt.valid  = ifid_vld_p0;
    id_ex_nxt.pc     = ifid_pc_p0;
    id_ex_nxt.imm    = imm_in;
    id_ex_nxt.rs1    = ifid_instr_p0[19:15];
    id_ex_nxt.rs2    = ifid_instr_p0[24:20];
    id_ex_nxt.rd     = ifid_instr_p0[11:7];
    id_ex_nxt.opcode = ifid_instr_p0[6:0];
    id_ex_nxt.funct3 = ifid_instr_p0[14:12];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RUN;
      flush_cnt     <= '0;
      ifid_vld_p0   <= 1'b0;
      ifid_instr_p0 <= NOP;
      ifid_pc_p0    <= '0;
      id_ex_p1      <= '0;
      bubble_q      <= '0;
    end else begin
      if (redirect) begin
        if (FLUSH_CYCLES > 0) begin
          state     <= FLUSH;
          flush_cnt <= FLUSH_LOAD;
        end
      end else if (state == FLUSH) begin
        if (flush_cnt <= 3'd1) begin
          state     <= RUN;
          flush_cnt <= '0;
        end else begin
          flush_cnt <= flush_cnt - 3'd1;
        end
      end

      // IF/ID (p0) -> ID/EX (p1) stage boundary
      if (redirect) begin
        ifid_vld_p0    <= 1'b0;
        id_ex_p1.valid <= 1'b0;
      end else if (!ex_ready) begin
        // backpressure: both stages hold
      end else if (stall_ld) begin
        id_ex_p1.valid <= 1'b0;
        bubble_q       <= sat_inc(bubble_q);
      end else begin
        id_ex_p1    <= id_ex_nxt;
        ifid_vld_p0 <= accept;
        if (accept) begin
          ifid_instr_p0 <= if_instr;
          ifid_pc_p0    <= if_pc;
        end
      end
    end
  end

  assign id_instr     = ifid_vld_p0 ? ifid_instr_p0 : NOP;
  assign id_ex_valid  = id_ex_p1.valid;
  assign id_ex_pc     = id_ex_p1.pc;
  assign id_ex_imm    = id_ex_p1.imm;
  assign id_ex_rs1    = id_ex_p1.rs1;
  assign id_ex_rs2    = id_ex_p1.rs2;
  assign id_ex_rd     = id_ex_p1.rd;
  assign id_ex_opcode = id_ex_p1.opcode;
  assign id_ex_funct3 = id_ex_p1.funct3;
  assign bubble_cnt   = bubble_q;

endmodule

// File: doc/decode_issue_ctrl.md
Name: decode_issue_ctrl

Overview:
- Decode-stage sequencer for the 5-stage RISC-V pipeline.
- Owns the IF/ID and ID/EX pipeline registers, and drives the instruction into the immediate generator, which is a combinational sibling.
- Captures the immediate the generator returns into ID/EX.
- Inserts load-use bubbles, applies EX backpressure, and discards wrong-path fetches after a branch/jump redirect.
- Sits between the fetch unit and the execute stage.

Parameters:
- XLEN, 32, datapath/PC width.
- FLUSH_CYCLES, 1, cycles after a redirect during which incoming fetches are dropped (fetch latency); legal range 0..7.
- CNT_W, 16, width of the bubble performance counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- if_valid  in  1  fetch presents an instruction.
- if_instr  in  32  fetched instruction.
- if_pc  in  XLEN  PC of the fetched instruction.
- if_ready  out  1  decode accepts the fetch this cycle.
- id_instr  out  32  IF/ID instruction; feeds the immediate generator.
- imm_in  in  32  immediate-generator result for id_instr, same cycle.
- ex_ready  in  1  EX consumes ID/EX this cycle; 0 = backpressure.
- redirect  in  1  EX resolved a taken branch/jump; all younger instructions are wrong-path.
- id_ex_valid  out  1  ID/EX holds a real instruction.
- id_ex_pc  out  XLEN  ID/EX PC.
- id_ex_imm  out  32  ID/EX immediate.
- id_ex_rs1, id_ex_rs2, id_ex_rd  out  5 each  register fields.
- id_ex_opcode  out  7  instr[6:0].
- id_ex_funct3  out  3  instr[14:12].
- bubble_cnt  out  CNT_W  count of load-use bubbles inserted; saturates at all-ones.

Behaviour:
- Reset:
  - Clears IF/ID valid; id_instr = 32'h00000013 (NOP).
  - Clears id_ex_valid, and sets all id_ex_* fields to 0.
  - bubble_cnt = 0; state = RUN; flush counter = 0.
  - A reset asserted mid-stall or mid-flush overrides everything.
- States:
  - RUN: normal operation.
  - FLUSH: drops fetches.
  - Transitions:
    - RUN -> FLUSH on redirect when FLUSH_CYCLES > 0; counter loads FLUSH_CYCLES.
    - In FLUSH, the counter decrements each cycle; FLUSH -> RUN when it reaches 1.
    - A redirect while in FLUSH reloads the counter.
  - While in FLUSH:
    - if_ready = 1.
    - Fetches are discarded and IF/ID valid stays 0.
- Source-use decode from the IF/ID opcode:
  - rs1 used for opcodes 0010011, 0000011, 0100011, 1100011, 0110011, 1100111.
  - rs2 used for opcodes 0100011, 1100011, 0110011.
  - U-type and J-type use neither.
- Load-use hazard, combinational: all of the following must hold.
  - id_ex_valid.
  - id_ex_opcode = 0000011.
  - id_ex_rd != 0.
  - IF/ID valid.
  - Either rs1 is used and equals id_ex_rd, or rs2 is used and equals id_ex_rd.
- Priority each cycle: rst > redirect > !ex_ready > load-use > advance.
  - redirect:
    - IF/ID valid <= 0.
    - id_ex_valid <= 0; other id_ex fields hold.
    - if_ready = 0 that cycle.
  - !ex_ready: both registers hold; if_ready = 0.
  - load-use:
    - ID/EX <= bubble (valid 0).
    - IF/ID holds; if_ready = 0.
    - bubble_cnt increments.
    - Exactly one bubble per hazard, because the next cycle ID/EX no longer holds the load.
  - advance:
    - ID/EX <= IF/ID contents plus imm_in; id_ex_valid <= IF/ID valid.
    - IF/ID <= fetch if if_valid && if_ready, else IF/ID valid <= 0.
    - if_ready = 1.
- Latency: accepted fetch -> ID/EX valid in 2 cycles with no stalls.
- imm_in is sampled only on advance; no other timing relation to the generator.
- id_instr = IF/ID instruction when valid, NOP when invalid, so imm_in is always defined.

Decomposition:
- Shared package riscv_pkg holds:
  - opcode localparams (OP_IMM, LOAD, STORE, BRANCH, OP, JALR, LUI, JAL);
  - NOP constant;
  - id_ex_t packed struct (valid, pc, imm, rs1, rs2, rd, opcode, funct3);
  - ctrl_state_t enum {RUN, FLUSH}.
- One natural sub-module, hazard_detect: combinational load-use check (IF/ID fields plus ID/EX load/rd -> stall).

Test Plan:
- Reset with if_valid=1 -> the next 2 cycles show id_ex_valid=0, bubble_cnt=0, id_instr=32'h00000013.
- Stream: addi x1,x0,5 (0x00500093) at pc 0x100 -> two cycles later id_ex_valid=1, id_ex_pc=0x100, id_ex_imm=5, id_ex_rd=1.
- Load-use: lw x5,0(x2) then add x6,x5,x3 -> exactly one cycle with id_ex_valid=0 and if_ready=0; bubble_cnt=1; the add reaches ID/EX the following cycle.
- No false hazard: lw x5 then lui x5,0x12345 -> no bubble; lw x0 then add x6,x0,x3 -> no bubble; bubble_cnt stays 0.
- Redirect with FLUSH_CYCLES=1 -> id_ex_valid=0 next cycle; the next fetch is dropped; the second fetch reaches ID/EX.
- ex_ready=0 for 3 cycles during a load-use stall -> ID/EX and IF/ID hold unchanged; bubble_cnt increments once, only after ex_ready returns.
